// File: rtl/p2s_tx_pkg.sv
// p2s_tx_pkg: shared definitions for the parallel-to-serial transmitter.
//   W_DEF   : default word width (matches the s2p receiver output width)
//   GAP_DEF : default idle clocks between consecutive words
//   p2s_state_e : transmitter FSM state encoding
//   cnt_w() : counter width helper, never narrower than one bit
package p2s_tx_pkg;

    localparam int unsigned W_DEF   = 10;
    localparam int unsigned GAP_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } p2s_state_e;

    // Bits needed to count 0..n-1; at least one so GAP=0 still yields a legal vector.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/p2s_tx_if.sv
// p2s_tx_if: parallel word handshake into the transmitter.
//   din       : parallel word (W bits)
//   din_valid : source holds a word on din
//   din_ready : transmitter hold register can accept
// Transfer happens on a clk posedge where din_valid && din_ready.
//   master : word source
//   slave  : transmitter
interface p2s_tx_if
    import p2s_tx_pkg::*;
#(
    parameter int unsigned W = W_DEF
);

    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);

endinterface

// File: rtl/p2s_tx.sv
// p2s_tx: parallel-to-serial transmitter. Buffers one word, shifts it out
// MSB-first one bit per clk, with an enable and a start-of-frame strobe.
// Ports:
//   clk        : clock, all state on posedge
//   rst_n      : asynchronous reset, active low
//   in_if      : slave side of the din/din_valid/din_ready handshake
//   dout       : serial data bit (0 whenever dout_en is low)
//   dout_en    : dout carries a valid bit this cycle
//   sof        : high on the MSB bit of each word
//   busy       : shifter or hold register occupied
//   words_sent : count of fully shifted words, wraps 255->0
module p2s_tx
    import p2s_tx_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned GAP = GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    p2s_tx_if.slave    in_if,
    output logic       dout,
    output logic       dout_en,
    output logic       sof,
    output logic       busy,
    output logic [7:0] words_sent
);

    localparam int unsigned     BCW     = cnt_w(W);
    localparam int unsigned     GCW     = cnt_w(GAP + 1);
    localparam logic [BCW-1:0]  BIT_TOP = BCW'(W - 1);
    localparam logic [GCW-1:0]  GAP_TOP = (GAP > 0) ? GCW'(GAP - 1) : '0;

    p2s_state_e     state;
    logic [W-1:0]   hold;
    logic           hold_full;
    logic [W-1:0]   shreg;
    logic [BCW-1:0] bitcnt;
    logic [GCW-1:0] gapcnt;

    logic accept;
    logic word_end;
    logic gap_end;
    logic slot_free;
    logic load;
    logic hold_full_nxt;
    logic idle_nxt;

    // Ready depends only on registered state (and reset), never on din_valid.
    assign in_if.din_ready = rst_n && !hold_full;

    always_comb begin
        accept        = in_if.din_valid && in_if.din_ready;
        word_end      = (state == ST_SHIFT) && (bitcnt == '0);
        gap_end       = (state == ST_GAP) && (gapcnt == '0);
        // The shifter can take a new word now: idle, LSB ending with no gap, or gap ending.
        slot_free     = (state == ST_IDLE) || (word_end && (GAP == 0)) || gap_end;
        load          = slot_free && hold_full;
        hold_full_nxt = accept || (hold_full && !load);
        idle_nxt      = slot_free && !hold_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            gapcnt     <= '0;
            dout       <= 1'b0;
            dout_en    <= 1'b0;
            sof        <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            busy      <= !idle_nxt || hold_full_nxt;
            hold_full <= hold_full_nxt;
            if (accept) begin
                hold <= in_if.din;
            end
            if (word_end) begin
                words_sent <= words_sent + 8'd1;
            end

            if (load) begin
                // MSB goes straight to the output register; shreg keeps the remaining bits.
                state   <= ST_SHIFT;
                shreg   <= {hold[W-2:0], 1'b0};
                bitcnt  <= BIT_TOP;
                dout    <= hold[W-1];
                dout_en <= 1'b1;
                sof     <= 1'b1;
            end else if (word_end && (GAP != 0)) begin
                state   <= ST_GAP;
                gapcnt  <= GAP_TOP;
                dout    <= 1'b0;
                dout_en <= 1'b0;
                sof     <= 1'b0;
            end else if (idle_nxt) begin
                state   <= ST_IDLE;
                dout    <= 1'b0;
                dout_en <= 1'b0;
                sof     <= 1'b0;
            end else if (state == ST_SHIFT) begin
                dout    <= shreg[W-1];
                shreg   <= {shreg[W-2:0], 1'b0};
                bitcnt  <= bitcnt - 1'b1;
                dout_en <= 1'b1;
                sof     <= 1'b0;
            end else if (state == ST_GAP) begin
                gapcnt  <= gapcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p2s_tx.sv
// tb_p2s_tx: directed bench for p2s_tx. dut0 runs with GAP=0, dut2 with GAP=2.
// Inputs are driven and outputs sampled on the falling edge.
module tb_p2s_tx;
    import p2s_tx_pkg::*;

    localparam int unsigned W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p2s_tx_if #(.W(W)) if0 ();
    p2s_tx_if #(.W(W)) if2 ();

    logic       d0, e0, s0, b0;
    logic [7:0] ws0;
    logic       d2, e2, s2, b2;
    logic [7:0] ws2;

    p2s_tx #(.W(W), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0),
        .dout(d0), .dout_en(e0), .sof(s0), .busy(b0), .words_sent(ws0)
    );

    p2s_tx #(.W(W), .GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_if(if2),
        .dout(d2), .dout_en(e2), .sof(s2), .busy(b2), .words_sent(ws2)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] ws_exp0  = '0;
    logic [7:0] ws_exp2  = '0;

    logic cap_d [64];
    logic cap_e [64];
    logic cap_s [64];
    int   cap_lat;

    function automatic logic bit_of(input logic [W-1:0] w, input int i);
        return w[W-1-i];
    endfunction

    function automatic logic rdy(input int s);
        return (s == 2) ? if2.din_ready : if0.din_ready;
    endfunction

    function automatic logic en_of(input int s);
        return (s == 2) ? e2 : e0;
    endfunction

    function automatic logic busy_of(input int s);
        return (s == 2) ? b2 : b0;
    endfunction

    task automatic set_in(input int s, input logic [W-1:0] w, input logic v);
        if (s == 2) begin
            if2.din = w; if2.din_valid = v;
        end else begin
            if0.din = w; if0.din_valid = v;
        end
    endtask

    // Present a word, hold it until accepted, return on the negedge after the accept edge.
    task automatic push(input int s, input logic [W-1:0] w);
        int n = 0;
        set_in(s, w, 1'b1);
        while (!rdy(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL push_timeout dut=%0d waited=%0d required<100", s, n);
        end
        @(negedge clk);
        set_in(s, w, 1'b0);
    endtask

    // Wait for the first dout_en, then record n consecutive cycles.
    task automatic capture(input int s, input int n);
        int k = 1;
        @(negedge clk);
        while (!en_of(s) && k < 60) begin
            @(negedge clk);
            k++;
        end
        cap_lat = k;
        checks++;
        if (k >= 60) begin
            failures++;
            $display("FAIL capture_timeout dut=%0d waited=%0d required<60", s, k);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_d[i] = (s == 2) ? d2 : d0;
            cap_e[i] = (s == 2) ? e2 : e0;
            cap_s[i] = (s == 2) ? s2 : s0;
        end
    endtask

    task automatic wait_idle(input int s);
        int n = 0;
        @(negedge clk);
        while (busy_of(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL idle_timeout dut=%0d waited=%0d required<100", s, n);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({d0, e0, s0, b0, ws0} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000", {d0, e0, s0, b0, ws0});
        end
        checks++;
        if (if0.din_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low got=%b want=0", if0.din_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (if0.din_ready !== 1'b1 || if2.din_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_high got=%b%b want=11", if0.din_ready, if2.din_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [W-1:0] w = 10'h2A5;
        fork
            push(0, w);
            capture(0, 10);
        join
        checks++;
        if (cap_lat !== 2) begin
            failures++;
            $display("FAIL single_latency got=%0d want=2", cap_lat);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cap_d[i] !== bit_of(w, i) || cap_e[i] !== 1'b1 || cap_s[i] !== (i == 0)) begin
                failures++;
                $display("FAIL single_bit%0d got d/en/sof=%b%b%b want=%b1%b",
                         i, cap_d[i], cap_e[i], cap_s[i], bit_of(w, i), (i == 0));
            end
        end
        ws_exp0++;
        @(negedge clk);
        checks++;
        if (ws0 !== ws_exp0 || b0 !== 1'b0 || e0 !== 1'b0 || d0 !== 1'b0) begin
            failures++;
            $display("FAIL single_end got ws=%0d busy=%b en=%b d=%b want ws=%0d busy=0 en=0 d=0",
                     ws0, b0, e0, d0, ws_exp0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] wa = 10'h3FF;
        logic [W-1:0] wb = 10'h001;
        logic         ed;
        fork
            begin push(0, wa); push(0, wb); end
            capture(0, 20);
        join
        for (int i = 0; i < 20; i++) begin
            ed = (i < 10) ? bit_of(wa, i) : bit_of(wb, i - 10);
            checks++;
            if (cap_d[i] !== ed || cap_e[i] !== 1'b1 || cap_s[i] !== (i == 0 || i == 10)) begin
                failures++;
                $display("FAIL b2b_bit%0d got d/en/sof=%b%b%b want=%b1%b",
                         i, cap_d[i], cap_e[i], cap_s[i], ed, (i == 0 || i == 10));
            end
        end
        ws_exp0 += 8'd2;
        wait_idle(0);
        checks++;
        if (ws0 !== ws_exp0) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=%0d", ws0, ws_exp0);
        end
    endtask

    task automatic test_gap();
        logic [W-1:0] wa = 10'h3FF;
        logic [W-1:0] wb = 10'h001;
        logic         ed, ee, es;
        fork
            begin push(2, wa); push(2, wb); end
            capture(2, 22);
        join
        for (int i = 0; i < 22; i++) begin
            ee = (i < 10) || (i >= 12);
            ed = (i < 10) ? bit_of(wa, i) : ((i >= 12) ? bit_of(wb, i - 12) : 1'b0);
            es = (i == 0) || (i == 12);
            checks++;
            if (cap_d[i] !== ed || cap_e[i] !== ee || cap_s[i] !== es) begin
                failures++;
                $display("FAIL gap_cycle%0d got d/en/sof=%b%b%b want=%b%b%b",
                         i, cap_d[i], cap_e[i], cap_s[i], ed, ee, es);
            end
        end
        ws_exp2 += 8'd2;
        wait_idle(2);
        checks++;
        if (ws2 !== ws_exp2) begin
            failures++;
            $display("FAIL gap_count got=%0d want=%0d", ws2, ws_exp2);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] wv [3];
        logic         ed;
        wv[0] = 10'h2CC; wv[1] = 10'h133; wv[2] = 10'h3C3;
        fork
            begin
                push(0, wv[0]);
                push(0, wv[1]);
                checks++;
                if (if0.din_ready !== 1'b0 || b0 !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold_full got ready=%b busy=%b want ready=0 busy=1",
                             if0.din_ready, b0);
                end
                push(0, wv[2]);
            end
            capture(0, 30);
        join
        for (int i = 0; i < 30; i++) begin
            ed = bit_of(wv[i / 10], i % 10);
            checks++;
            if (cap_d[i] !== ed || cap_e[i] !== 1'b1 || cap_s[i] !== (i % 10 == 0)) begin
                failures++;
                $display("FAIL bp_bit%0d got d/en/sof=%b%b%b want=%b1%b",
                         i, cap_d[i], cap_e[i], cap_s[i], ed, (i % 10 == 0));
            end
        end
        @(negedge clk);
        checks++;
        if (e0 !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup got en=%b want=0", e0);
        end
        ws_exp0 += 8'd3;
        wait_idle(0);
        checks++;
        if (ws0 !== ws_exp0) begin
            failures++;
            $display("FAIL bp_count got=%0d want=%0d", ws0, ws_exp0);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] w = 10'h0AA;
        int           stray = 0;
        fork
            push(0, 10'h155);
            capture(0, 5);
        join
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({d0, e0, s0, b0, ws0} !== 12'h000 || if0.din_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h ready=%b want=000 ready=0",
                     {d0, e0, s0, b0, ws0}, if0.din_ready);
        end
        ws_exp0 = '0;
        ws_exp2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (e0 !== 1'b0 || b0 !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midreset_no_resume got=%0d active cycles want=0", stray);
        end
        fork
            push(0, w);
            capture(0, 10);
        join
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cap_d[i] !== bit_of(w, i) || cap_e[i] !== 1'b1 || cap_s[i] !== (i == 0)) begin
                failures++;
                $display("FAIL midreset_bit%0d got d/en/sof=%b%b%b want=%b1%b",
                         i, cap_d[i], cap_e[i], cap_s[i], bit_of(w, i), (i == 0));
            end
        end
        ws_exp0++;
        wait_idle(0);
        checks++;
        if (ws0 !== ws_exp0) begin
            failures++;
            $display("FAIL midreset_count got=%0d want=%0d", ws0, ws_exp0);
        end
    endtask

    task automatic test_loopback_wrap();
        logic [W-1:0] rx = '0;
        fork
            push(0, 10'd256);
            capture(0, 10);
        join
        // Receiver model: shift in MSB-first on every enabled bit.
        for (int i = 0; i < 10; i++) begin
            if (cap_e[i]) rx = {rx[W-2:0], cap_d[i]};
        end
        checks++;
        if (rx !== 10'd256) begin
            failures++;
            $display("FAIL loopback_word got=%0d want=256", rx);
        end
        ws_exp0++;
        for (int i = 0; i < 253; i++) begin
            push(0, W'(i));
            ws_exp0++;
        end
        wait_idle(0);
        checks++;
        if (ws0 !== ws_exp0 || ws_exp0 !== 8'd255) begin
            failures++;
            $display("FAIL wrap_255 got=%0d want=%0d", ws0, ws_exp0);
        end
        push(0, 10'h3A5);
        ws_exp0++;
        wait_idle(0);
        checks++;
        if (ws0 !== ws_exp0) begin
            failures++;
            $display("FAIL wrap_0 got=%0d want=%0d", ws0, ws_exp0);
        end
    endtask

    initial begin
        set_in(0, '0, 1'b0);
        set_in(2, '0, 1'b0);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_gap();
        test_backpressure();
        test_reset_mid_word();
        test_loopback_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t limit=1000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
